// File: rtl/cnn_pkg.sv
// Shared CNN definitions: feature-map word/window geometry and the packer FSM states.
package cnn_pkg;
   localparam int unsigned WORD_W  = 16;
   localparam int unsigned N_WORDS = 27;
   localparam int unsigned FM_W    = WORD_W * N_WORDS;
   localparam int unsigned CNT_W   = 5;

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_WORDS - 1);

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } pack_state_t;
endpackage

// File: rtl/fm_window_packer_if.sv
// Word-stream input and packed-window output of the feature-map packer.
interface fm_window_packer_if;
   import cnn_pkg::*;

   logic [WORD_W-1:0] in_data;
   logic              in_valid;
   logic              in_last;
   logic              in_ready;
   logic [FM_W-1:0]   fm_data;
   logic              fm_valid;
   logic              fm_short;
   logic              fm_ready;

   modport slave (
      input  in_data, in_valid, in_last, fm_ready,
      output in_ready, fm_data, fm_valid, fm_short
   );

   modport master (
      output in_data, in_valid, in_last, fm_ready,
      input  in_ready, fm_data, fm_valid, fm_short
   );
endinterface

// File: rtl/fm_slot.sv
// Single-entry valid/ready holding register; accepts a load whenever empty or drained this cycle.
module fm_slot #(
   parameter int unsigned W = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_valid,
   input  logic [W-1:0] load_data,
   output logic         load_ready,
   output logic [W-1:0] out_data,
   output logic         out_valid,
   input  logic         out_ready
);
   logic [W-1:0] data_q;
   logic         valid_q;

   assign load_ready = !valid_q || out_ready;
   assign out_data   = data_q;
   assign out_valid  = valid_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= '0;
         valid_q <= 1'b0;
      end else if (load_valid && load_ready) begin
         data_q  <= load_data;
         valid_q <= 1'b1;
      end else if (out_ready) begin
         valid_q <= 1'b0;
      end
   end
endmodule

// File: rtl/fm_window_packer.sv
// Packs 27 16-bit feature-map words MSB-first into one 432-bit window for Loop_cnn.
module fm_window_packer
   import cnn_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   fm_window_packer_if.slave  bus
);
   pack_state_t      state_q, state_d;
   logic [CNT_W-1:0] wcnt_q, wcnt_d;
   logic [FM_W-1:0]  fill_q, fill_d, win;
   logic             short_q, short_d;
   logic             in_ready_q, in_ready_d;
   logic             accept, close, win_short;
   logic             slot_ready, load_valid, slot_valid;
   logic [FM_W:0]    load_data, slot_data;

   assign accept    = bus.in_valid && in_ready_q;
   assign close     = accept && ((wcnt_q == LAST_IDX) || bus.in_last);
   assign win_short = (wcnt_q != LAST_IDX);

   // Fill register with the current word merged in; unwritten slots remain zero.
   always_comb begin
      win = fill_q;
      for (int unsigned k = 0; k < N_WORDS; k++) begin
         if (wcnt_q == CNT_W'(k)) begin
            win[FM_W-1-WORD_W*k -: WORD_W] = bus.in_data;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      wcnt_d     = wcnt_q;
      fill_d     = fill_q;
      short_d    = short_q;
      in_ready_d = 1'b1;
      load_valid = 1'b0;
      load_data  = {win_short, win};
      case (state_q)
         FILL: begin
            if (close) begin
               wcnt_d = '0;
               if (slot_ready) begin
                  load_valid = 1'b1;
                  load_data  = {win_short, win};
                  fill_d     = '0;
                  short_d    = 1'b0;
               end else begin
                  fill_d     = win;
                  short_d    = win_short;
                  state_d    = HOLD;
                  in_ready_d = 1'b0;
               end
            end else if (accept) begin
               fill_d = win;
               wcnt_d = wcnt_q + 1'b1;
            end
         end
         HOLD: begin
            // Slot is occupied here, so slot_ready is exactly the window handshake.
            in_ready_d = 1'b0;
            if (slot_ready) begin
               load_valid = 1'b1;
               load_data  = {short_q, fill_q};
               fill_d     = '0;
               short_d    = 1'b0;
               state_d    = FILL;
               in_ready_d = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= FILL;
         wcnt_q     <= '0;
         fill_q     <= '0;
         short_q    <= 1'b0;
         in_ready_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wcnt_q     <= wcnt_d;
         fill_q     <= fill_d;
         short_q    <= short_d;
         in_ready_q <= in_ready_d;
      end
   end

   fm_slot #(.W(FM_W + 1)) u_out_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_valid (load_valid),
      .load_data  (load_data),
      .load_ready (slot_ready),
      .out_data   (slot_data),
      .out_valid  (slot_valid),
      .out_ready  (bus.fm_ready)
   );

   assign bus.in_ready = in_ready_q;
   assign bus.fm_valid = slot_valid;
   assign bus.fm_data  = slot_data[FM_W-1:0];
   assign bus.fm_short = slot_data[FM_W];
endmodule

// File: tb/tb_fm_window_packer.sv
// Directed self-checking bench for fm_window_packer.
module tb_fm_window_packer;
   import cnn_pkg::*;

   localparam logic [FM_W-1:0] KV_FM = 432'h192a_e9e9_3b7c_0ff0_a55a_1234_5678_9abc_def0_0f1e_2d3c_4b5a_6978_8796_a5b4_c3d2_e1f0_fedc_ba98_7654_3210_c0de_beef_cafe_f00d_8001_e325;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   fm_window_packer_if bus();

   fm_window_packer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int unsigned n_cmp = 0;
   int unsigned n_bad = 0;
   logic [FM_W-1:0] exp_fm;
   logic [WORD_W-1:0] kv_words [N_WORDS];

   function automatic logic [FM_W-1:0] seq_window(input logic [WORD_W-1:0] base);
      logic [FM_W-1:0] w = '0;
      for (int k = 0; k < N_WORDS; k++) w[FM_W-1-WORD_W*k -: WORD_W] = base + WORD_W'(k);
      return w;
   endfunction

   task automatic send(input logic [WORD_W-1:0] d, input logic l, output int unsigned stalls);
      stalls = 0;
      bus.in_data = d; bus.in_valid = 1'b1; bus.in_last = l;
      while (bus.in_ready !== 1'b1 && stalls < 100) begin
         @(posedge clk); #1;
         stalls++;
      end
      if (bus.in_ready !== 1'b1) begin
         n_cmp++; n_bad++;
         $display("FAIL send_timeout: in_ready=%b required 1", bus.in_ready);
      end else begin
         @(posedge clk); #1;
      end
      bus.in_valid = 1'b0; bus.in_last = 1'b0;
   endtask

   task automatic drain();
      bus.fm_ready = 1'b1;
      @(posedge clk); #1;
      bus.fm_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.in_data = '0; bus.in_valid = 1'b0; bus.in_last = 1'b0; bus.fm_ready = 1'b0;
      #12;
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
      n_cmp++; if (bus.fm_valid !== 1'b0) begin n_bad++; $display("FAIL rst_fm_valid: got %b want 0", bus.fm_valid); end
      n_cmp++; if (bus.fm_data !== '0) begin n_bad++; $display("FAIL rst_fm_data: got %h want 0", bus.fm_data); end
      n_cmp++; if (bus.fm_short !== 1'b0) begin n_bad++; $display("FAIL rst_fm_short: got %b want 0", bus.fm_short); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      #2;
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_ready_before_edge: got %b want 0", bus.in_ready); end
      @(posedge clk); #1;
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready_after_edge: got %b want 1", bus.in_ready); end
   endtask

   task automatic test_full_window();
      int unsigned st, total;
      total = 0;
      bus.fm_ready = 1'b1;
      for (int k = 0; k < 26; k++) begin send(WORD_W'(k + 1), 1'b0, st); total += st; end
      n_cmp++; if (bus.fm_valid !== 1'b0) begin n_bad++; $display("FAIL full_early_valid: got %b want 0", bus.fm_valid); end
      send(16'h001b, 1'b0, st); total += st;
      n_cmp++; if (bus.fm_valid !== 1'b1) begin n_bad++; $display("FAIL full_valid: got %b want 1", bus.fm_valid); end
      n_cmp++; if (bus.fm_data[431:416] !== 16'h0001) begin n_bad++; $display("FAIL full_word0: got %h want 0001", bus.fm_data[431:416]); end
      n_cmp++; if (bus.fm_data[15:0] !== 16'h001b) begin n_bad++; $display("FAIL full_word26: got %h want 001b", bus.fm_data[15:0]); end
      n_cmp++; if (bus.fm_short !== 1'b0) begin n_bad++; $display("FAIL full_short: got %b want 0", bus.fm_short); end
      n_cmp++; if (bus.fm_data !== seq_window(16'h0001)) begin n_bad++; $display("FAIL full_data: got %h want %h", bus.fm_data, seq_window(16'h0001)); end
      n_cmp++; if (total != 0) begin n_bad++; $display("FAIL full_stalls: got %0d want 0", total); end
      @(posedge clk); #1;
      n_cmp++; if (bus.fm_valid !== 1'b0) begin n_bad++; $display("FAIL full_valid_drop: got %b want 0", bus.fm_valid); end
      bus.fm_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      int unsigned st, total;
      total = 0;
      bus.fm_ready = 1'b1;
      for (int k = 0; k < 54; k++) begin
         send(WORD_W'(16'h0200 + k), 1'b0, st); total += st;
         if (k == 26) begin
            n_cmp++; if (bus.fm_data !== seq_window(16'h0200)) begin n_bad++; $display("FAIL b2b_win1: got %h want %h", bus.fm_data, seq_window(16'h0200)); end
         end
         if (k == 27) begin
            n_cmp++; if (bus.fm_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_gap_valid: got %b want 0", bus.fm_valid); end
         end
      end
      n_cmp++; if (bus.fm_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_win2_valid: got %b want 1", bus.fm_valid); end
      n_cmp++; if (bus.fm_data !== seq_window(16'h021b)) begin n_bad++; $display("FAIL b2b_win2: got %h want %h", bus.fm_data, seq_window(16'h021b)); end
      n_cmp++; if (total != 0) begin n_bad++; $display("FAIL b2b_stalls: got %0d want 0", total); end
      @(posedge clk); #1;
      bus.fm_ready = 1'b0;
      n_cmp++; if (bus.fm_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_drained: got %b want 0", bus.fm_valid); end
   endtask

   task automatic test_backpressure();
      int unsigned st, total;
      total = 0;
      bus.fm_ready = 1'b0;
      for (int k = 0; k < 54; k++) begin
         send(WORD_W'(16'h1000 + k), 1'b0, st); total += st;
         if (k == 40) begin
            n_cmp++; if (bus.fm_data !== seq_window(16'h1000) || bus.fm_valid !== 1'b1) begin n_bad++; $display("FAIL bp_hold_mid: got v=%b %h want v=1 %h", bus.fm_valid, bus.fm_data, seq_window(16'h1000)); end
         end
      end
      n_cmp++; if (total != 0) begin n_bad++; $display("FAIL bp_stalls: got %0d want 0", total); end
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_hold_ready: got %b want 0", bus.in_ready); end
      n_cmp++; if (bus.fm_data !== seq_window(16'h1000)) begin n_bad++; $display("FAIL bp_hold_data: got %h want %h", bus.fm_data, seq_window(16'h1000)); end
      @(posedge clk); #1;
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_hold_ready2: got %b want 0", bus.in_ready); end
      n_cmp++; if (bus.fm_data !== seq_window(16'h1000)) begin n_bad++; $display("FAIL bp_hold_data2: got %h want %h", bus.fm_data, seq_window(16'h1000)); end
      bus.fm_ready = 1'b1;
      @(posedge clk); #1;
      bus.fm_ready = 1'b0;
      n_cmp++; if (bus.fm_valid !== 1'b1) begin n_bad++; $display("FAIL bp_win2_valid: got %b want 1", bus.fm_valid); end
      n_cmp++; if (bus.fm_data !== seq_window(16'h101b)) begin n_bad++; $display("FAIL bp_win2_data: got %h want %h", bus.fm_data, seq_window(16'h101b)); end
      n_cmp++; if (bus.fm_short !== 1'b0) begin n_bad++; $display("FAIL bp_win2_short: got %b want 0", bus.fm_short); end
      n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_ready: got %b want 1", bus.in_ready); end
      drain();
      n_cmp++; if (bus.fm_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drained: got %b want 0", bus.fm_valid); end
   endtask

   task automatic test_short();
      int unsigned st;
      bus.fm_ready = 1'b0;
      for (int k = 0; k < 4; k++) send(16'he9e9, 1'b0, st);
      send(16'he9e9, 1'b1, st);
      exp_fm = '0;
      for (int k = 0; k < 5; k++) exp_fm[FM_W-1-WORD_W*k -: WORD_W] = 16'he9e9;
      n_cmp++; if (bus.fm_valid !== 1'b1) begin n_bad++; $display("FAIL short_valid: got %b want 1", bus.fm_valid); end
      n_cmp++; if (bus.fm_short !== 1'b1) begin n_bad++; $display("FAIL short_flag: got %b want 1", bus.fm_short); end
      n_cmp++; if (bus.fm_data !== exp_fm) begin n_bad++; $display("FAIL short_data: got %h want %h", bus.fm_data, exp_fm); end
      n_cmp++; if (bus.fm_data[351:0] !== '0) begin n_bad++; $display("FAIL short_pad: got %h want 0", bus.fm_data[351:0]); end
      drain();
      for (int k = 0; k < 27; k++) send(WORD_W'(16'h2000 + k), 1'b0, st);
      n_cmp++; if (bus.fm_data[431:416] !== 16'h2000) begin n_bad++; $display("FAIL short_next_slot0: got %h want 2000", bus.fm_data[431:416]); end
      n_cmp++; if (bus.fm_data !== seq_window(16'h2000)) begin n_bad++; $display("FAIL short_next_data: got %h want %h", bus.fm_data, seq_window(16'h2000)); end
      n_cmp++; if (bus.fm_short !== 1'b0) begin n_bad++; $display("FAIL short_next_flag: got %b want 0", bus.fm_short); end
      drain();
   endtask

   task automatic test_exact_last();
      int unsigned st;
      bus.fm_ready = 1'b0;
      for (int k = 0; k < 10; k++) send(WORD_W'(16'h3000 + k), 1'b0, st);
      bus.in_last = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      bus.in_last = 1'b0;
      n_cmp++; if (bus.fm_valid !== 1'b0) begin n_bad++; $display("FAIL last_without_valid: got %b want 0", bus.fm_valid); end
      for (int k = 10; k < 26; k++) send(WORD_W'(16'h3000 + k), 1'b0, st);
      send(16'h301a, 1'b1, st);
      n_cmp++; if (bus.fm_valid !== 1'b1) begin n_bad++; $display("FAIL exact_valid: got %b want 1", bus.fm_valid); end
      n_cmp++; if (bus.fm_short !== 1'b0) begin n_bad++; $display("FAIL exact_short: got %b want 0", bus.fm_short); end
      n_cmp++; if (bus.fm_data !== seq_window(16'h3000)) begin n_bad++; $display("FAIL exact_data: got %h want %h", bus.fm_data, seq_window(16'h3000)); end
      drain();
      send(16'h4444, 1'b1, st);
      exp_fm = '0;
      exp_fm[431:416] = 16'h4444;
      n_cmp++; if (bus.fm_short !== 1'b1) begin n_bad++; $display("FAIL one_word_short: got %b want 1", bus.fm_short); end
      n_cmp++; if (bus.fm_data !== exp_fm) begin n_bad++; $display("FAIL one_word_data: got %h want %h", bus.fm_data, exp_fm); end
      drain();
   endtask

   task automatic test_known_vector();
      int unsigned st;
      kv_words = '{16'h192a, 16'he9e9, 16'h3b7c, 16'h0ff0, 16'ha55a, 16'h1234, 16'h5678, 16'h9abc, 16'hdef0,
                   16'h0f1e, 16'h2d3c, 16'h4b5a, 16'h6978, 16'h8796, 16'ha5b4, 16'hc3d2, 16'he1f0, 16'hfedc,
                   16'hba98, 16'h7654, 16'h3210, 16'hc0de, 16'hbeef, 16'hcafe, 16'hf00d, 16'h8001, 16'he325};
      bus.fm_ready = 1'b0;
      for (int k = 0; k < N_WORDS; k++) send(kv_words[k], 1'b0, st);
      n_cmp++; if (bus.fm_data !== KV_FM) begin n_bad++; $display("FAIL kv_data: got %h want %h", bus.fm_data, KV_FM); end
      n_cmp++; if (bus.fm_short !== 1'b0) begin n_bad++; $display("FAIL kv_short: got %b want 0", bus.fm_short); end
      drain();
   endtask

   task automatic test_mid_reset();
      int unsigned st, seen;
      bus.fm_ready = 1'b0;
      for (int k = 0; k < 27; k++) send(WORD_W'(16'h5000 + k), 1'b0, st);
      for (int k = 0; k < 10; k++) send(WORD_W'(16'h6000 + k), 1'b0, st);
      n_cmp++; if (bus.fm_valid !== 1'b1) begin n_bad++; $display("FAIL mr_pre_valid: got %b want 1", bus.fm_valid); end
      rst_n = 1'b0;
      #1;
      n_cmp++; if (bus.fm_valid !== 1'b0) begin n_bad++; $display("FAIL mr_valid: got %b want 0", bus.fm_valid); end
      n_cmp++; if (bus.fm_data !== '0) begin n_bad++; $display("FAIL mr_data: got %h want 0", bus.fm_data); end
      n_cmp++; if (bus.fm_short !== 1'b0) begin n_bad++; $display("FAIL mr_short: got %b want 0", bus.fm_short); end
      n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL mr_ready: got %b want 0", bus.in_ready); end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      for (int k = 0; k < 27; k++) send(WORD_W'(16'h7000 + k), 1'b0, st);
      n_cmp++; if (bus.fm_valid !== 1'b1) begin n_bad++; $display("FAIL mr_fresh_valid: got %b want 1", bus.fm_valid); end
      n_cmp++; if (bus.fm_data !== seq_window(16'h7000)) begin n_bad++; $display("FAIL mr_fresh_data: got %h want %h", bus.fm_data, seq_window(16'h7000)); end
      n_cmp++; if (bus.fm_short !== 1'b0) begin n_bad++; $display("FAIL mr_fresh_short: got %b want 0", bus.fm_short); end
      bus.fm_ready = 1'b1;
      seen = 0;
      repeat (30) begin
         @(posedge clk); #1;
         if (bus.fm_valid === 1'b1) seen++;
      end
      bus.fm_ready = 1'b0;
      n_cmp++; if (seen != 0) begin n_bad++; $display("FAIL mr_extra_windows: got %0d valid cycles want 0", seen); end
   endtask

   initial begin
      test_reset();
      test_full_window();
      test_back_to_back();
      test_backpressure();
      test_short();
      test_exact_last();
      test_known_vector();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/fm_window_packer.md
# fm_window_packer

Upstream feeder for `Loop_cnn`. Accepts a stream of 16-bit feature-map words with valid/ready handshaking and packs each group of 27 words (one 3×3×3 window) into the 432-bit `input_fm` vector. Presents each packed window to the CNN stage on a registered valid/ready output. A two-slot arrangement (fill register plus output register) sustains one word per clock with no bubbles between windows.

## Interface
- `WORD_W`, 16: width of one feature-map word.
- `N_WORDS`, 27: words per window.
- `FM_W`, `WORD_W*N_WORDS` (432): packed window width; must equal the `Loop_cnn` `input_fm` width.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `in_data`  in  WORD_W  incoming word.
- `in_valid`  in  1  `in_data`/`in_last` are valid.
- `in_last`  in  1  final word of a frame; closes the current window early.
- `in_ready`  out  1  block accepts a word this cycle.
- `fm_data`  out  FM_W  packed window; connects to `Loop_cnn.input_fm`.
- `fm_valid`  out  1  `fm_data` holds an unconsumed window.
- `fm_short`  out  1  current window was zero-padded because of `in_last`.
- `fm_ready`  in  1  consumer takes the window this cycle.

## Operation
- Word accept: `in_valid & in_ready`. Window handshake: `fm_valid & fm_ready`.
- Packing order is MSB-first:
  - Word index k (0..26) is written to bits [FM_W-1-16k -: 16].
  - Word 0 lands in [431:416]; word 26 lands in [15:0].
- Word counter `wcnt` runs 0..26:
  - Increments on each accept.
  - Returns to 0 when a window closes.
- A window closes on an accepted word when `wcnt==26` or `in_last==1`.
  - Closed at `wcnt<26` by `in_last`: unwritten slots are 0 and the short flag is set.
  - `in_last` at `wcnt==26`: normal window, short flag clear.
  - `in_last` is ignored unless a word is accepted in that cycle.
- State machine:
  - FILL: fill register accumulating; `in_ready=1`.
  - HOLD: fill register complete but output register occupied; `in_ready=0`.
- FILL → HOLD on window close while the output register is occupied and not being drained in that cycle.
- A closed window moves to the output register in the same edge if the output register is empty or drained that cycle.
- HOLD → FILL on a window handshake. The held window moves to the output register at that edge, `in_ready` returns to 1 in the next cycle, and the fill register clears to 0.
- Output register holds `fm_data`/`fm_short`, which stay stable while `fm_valid & !fm_ready`.
- Arithmetic: no data arithmetic; `wcnt` is 5 bits and never exceeds 26.

## Timing
- Reset values:
  - `fm_valid=0`, `fm_data=0`, `fm_short=0`, `in_ready=0`.
  - State FILL, `wcnt=0`, fill register 0.
- `in_ready` is registered. It rises at the first `clk` edge after `rst_n` deasserts.
- Latency: word 26 accepted at edge N gives `fm_valid=1` after edge N, presenting the full window.
- Throughput: with `fm_ready` held high, windows appear every 27 cycles with `in_ready` constantly 1.
- `rst_n` asserted mid-window or mid-HOLD:
  - Immediately returns all state and outputs to reset values.
  - The partial window is discarded and no output is produced for it.
- `fm_valid` drops after a handshake edge unless a new window is transferred at that same edge.

## Structure
- Shared package `cnn_pkg` holds `WORD_W`, `N_WORDS`, `FM_W` and the FILL/HOLD state enum. `Loop_cnn` and its testbench use the same package.
- Sub-module `fm_slot`: a FM_W+1-bit valid/ready holding register with load/drain handshake, instantiated once as the output register. The top level holds the counter, the fill register and the FSM.

## Test plan
- Full window:
  - Stimulus: after reset, stream 27 words 0x0001..0x001b back-to-back with `fm_ready=1`.
  - Required: one cycle after the last accept, `fm_valid=1`, `fm_data[431:416]=0x0001`, `fm_data[15:0]=0x001b`, `fm_short=0`.
- Backpressure:
  - Stimulus: `fm_ready=0`; stream 54 words.
  - Required: first window held stable; after word 53, `in_ready=0` (HOLD).
  - Required on releasing `fm_ready` for one cycle: second window appears next cycle, and `in_ready=1` one cycle after the handshake.
- Short window:
  - Stimulus: 5 words 0xe9e9 with `in_last` on the 5th.
  - Required: `fm_data[431:352]` all 0xe9e9, bits [351:0]=0, `fm_short=1`; next window starts at slot 0.
- Exact-end last:
  - Stimulus: `in_last` on word 26.
  - Required: normal window with `fm_short=0`.
- Mid-window reset:
  - Stimulus: assert `rst_n=0` after 10 words.
  - Required: outputs return to reset values immediately.
  - Stimulus: then send 27 fresh words.
  - Required: exactly one window containing only the fresh words.
- Known vector:
  - Stimulus: feed the 27 words of 0x192a_e9e9_…_e325 in MSB-first order.
  - Required: `fm_data` equals that 432-bit value bit-exactly.
